// File: rtl/code_detector_param.sv
// Colour-code lock: Start, then CODE_LEN one-hot {R,G,B} symbols; pulses U on match, Fail on error,
// locks out after MAX_FAIL consecutive failures. Optional macro CODE_TIMEOUT_EN adds an idle timeout.
module code_detector_param #(
    parameter int unsigned                CODE_LEN       = 4,
    parameter logic [3*CODE_LEN-1:0]      DEFAULT_CODE   = 12'b100_010_001_100,
    parameter int unsigned                MAX_FAIL       = 3,
    parameter int unsigned                LOCK_CYCLES    = 16,
    parameter int unsigned                TIMEOUT_CYCLES = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic                  Red,
    input  logic                  Green,
    input  logic                  Blue,
    input  logic                  CodeLoad,
    input  logic [3*CODE_LEN-1:0] CodeIn,
    output logic                  U,
    output logic                  Fail,
    output logic                  Locked,
    output logic                  Busy
);

    localparam int unsigned IDX_W = $clog2(CODE_LEN + 1);
    localparam int unsigned FC_W  = $clog2(MAX_FAIL + 1);
    localparam int unsigned LC_W  = $clog2(LOCK_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);
    localparam logic [LC_W-1:0]  LC_INIT  = LC_W'(LOCK_CYCLES);

    if (CODE_LEN < 1 || MAX_FAIL < 1 || LOCK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("code_detector_param: all size parameters must be >= 1");
    end

    typedef enum logic [1:0] {S_WAIT, S_ENTRY, S_OPEN, S_LOCK} state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [FC_W-1:0]       fail_cnt_q;
    logic [FC_W-1:0]       fail_cnt_d;
    logic [LC_W-1:0]       lock_q;
    logic [3*CODE_LEN-1:0] code_q;
    logic                  u_q, fail_q, locked_q, busy_q;

    logic [2:0] sym;
    logic [2:0] exp_sym;
    logic       sym_idle;
    logic       sym_ok;
    logic       load_ok;
    logic       timeout;

    function automatic logic is_onehot3(input logic [2:0] s);
        return (s == 3'b100) || (s == 3'b010) || (s == 3'b001);
    endfunction

    assign sym      = {Red, Green, Blue};
    assign sym_idle = (sym == 3'b000);
    assign sym_ok   = is_onehot3(sym) && (sym == exp_sym);

    always_comb begin
        exp_sym = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (idx_q == i[IDX_W-1:0]) exp_sym = code_q[3*i +: 3];
        end
    end

    always_comb begin
        load_ok = 1'b1;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (!is_onehot3(CodeIn[3*i +: 3])) load_ok = 1'b0;
        end
    end

    // Saturating: lockout fires on reaching FC_MAX, so the counter never needs to wrap.
    assign fail_cnt_d = (fail_cnt_q == FC_MAX) ? fail_cnt_q : fail_cnt_q + FC_W'(1);

`ifdef CODE_TIMEOUT_EN
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_q;

    assign timeout = sym_idle && (idle_q == TO_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            idle_q <= '0;
        end else if (state_q == S_ENTRY && !Start && sym_idle && !timeout) begin
            idle_q <= idle_q + TO_W'(1);
        end else begin
            idle_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_WAIT;
            idx_q      <= '0;
            fail_cnt_q <= '0;
            lock_q     <= '0;
            code_q     <= DEFAULT_CODE;
            u_q        <= 1'b0;
            fail_q     <= 1'b0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            u_q    <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (CodeLoad && load_ok) code_q <= CodeIn;
                    if (Start) begin
                        state_q <= S_ENTRY;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_ENTRY: begin
                    if (Start) begin
                        idx_q <= '0;
                    end else if (sym_ok) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_OPEN;
                            u_q     <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else if (!sym_idle || timeout) begin
                        fail_q     <= 1'b1;
                        fail_cnt_q <= fail_cnt_d;
                        busy_q     <= 1'b0;
                        if (fail_cnt_d == FC_MAX) begin
                            state_q  <= S_LOCK;
                            locked_q <= 1'b1;
                            lock_q   <= LC_INIT;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_OPEN: begin
                    fail_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_LOCK: begin
                    if (lock_q <= LC_W'(1)) begin
                        state_q    <= S_WAIT;
                        locked_q   <= 1'b0;
                        fail_cnt_q <= '0;
                    end else begin
                        lock_q <= lock_q - LC_W'(1);
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign U      = u_q;
    assign Fail   = fail_q;
    assign Locked = locked_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_code_detector_param.sv
// Self-checking bench for code_detector_param: directed table, lockout/load/reset sequences,
// exhaustive 4-symbol sweep and random stimulus against a behavioural model.
module tb_code_detector_param;

    localparam int unsigned CODE_LEN       = 4;
    localparam int unsigned MAX_FAIL       = 3;
    localparam int unsigned LOCK_CYCLES    = 16;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam logic [11:0] DEF   = 12'b100_010_001_100;
    localparam logic [11:0] BBBB  = 12'b001_001_001_001;
    localparam logic [11:0] WRONG = 12'b100_010_001_010;
    localparam logic [2:0]  SR = 3'b100, SG = 3'b010, SB = 3'b001, SI = 3'b000;

    logic        Clk, Rst, Start, Red, Green, Blue, CodeLoad;
    logic [11:0] CodeIn;
    logic        U, Fail, Locked, Busy;

    code_detector_param #(
        .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEF), .MAX_FAIL(MAX_FAIL),
        .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Red(Red), .Green(Green), .Blue(Blue),
        .CodeLoad(CodeLoad), .CodeIn(CodeIn), .U(U), .Fail(Fail), .Locked(Locked), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=waiting 1=entering 2=open 3=locked out
    int          m_phase, m_fails, m_lock_left, m_idle;
    bit          m_fail;
    logic [2:0]  m_code[CODE_LEN];
    logic [2:0]  typed[$];

    function automatic bit onehot(input logic [2:0] s);
        return $countones(s) == 1;
    endfunction

    function automatic bit code_valid(input logic [11:0] c);
        for (int i = 0; i < CODE_LEN; i++) if (!onehot(c[3*i +: 3])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_load(input logic [11:0] c);
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = c[3*i +: 3];
    endtask

    task automatic model_reset();
        m_phase = 0; m_fails = 0; m_lock_left = 0; m_idle = 0; m_fail = 1'b0;
        typed.delete();
        model_load(DEF);
    endtask

    task automatic model_error();
        m_fail = 1'b1;
        m_fails++;
        typed.delete();
        m_idle = 0;
        if (m_fails >= MAX_FAIL) begin
            m_phase = 3;
            m_lock_left = LOCK_CYCLES;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic model_step(input bit st, input logic [2:0] sy, input bit ld, input logic [11:0] ci);
        m_fail = 1'b0;
        case (m_phase)
            0: begin
                if (ld && code_valid(ci)) model_load(ci);
                if (st) begin m_phase = 1; typed.delete(); m_idle = 0; end
            end
            1: begin
                if (st) begin
                    typed.delete(); m_idle = 0;
                end else if (sy == 3'b000) begin
`ifdef CODE_TIMEOUT_EN
                    m_idle++;
                    if (m_idle >= TIMEOUT_CYCLES) model_error();
`endif
                end else begin
                    m_idle = 0;
                    if (onehot(sy) && sy == m_code[typed.size()]) begin
                        typed.push_back(sy);
                        if (typed.size() == CODE_LEN) m_phase = 2;
                    end else begin
                        model_error();
                    end
                end
            end
            2: begin m_fails = 0; m_phase = 0; end
            default: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_fails = 0; m_phase = 0; end
            end
        endcase
    endtask

    function automatic logic [3:0] model_out();
        return {m_phase == 2, m_fail, m_phase == 3, m_phase == 1};
    endfunction

    task automatic step(input bit st, input logic [2:0] sy,
                        input bit ld = 1'b0, input logic [11:0] ci = '0);
        Start = st; {Red, Green, Blue} = sy; CodeLoad = ld; CodeIn = ci;
        @(posedge Clk);
        model_step(st, sy, ld, ci);
        #1;
        check("model_outputs", {U, Fail, Locked, Busy}, model_out());
    endtask

    task automatic do_entry(input logic [11:0] seq, output bit saw_u, output bit saw_fail);
        saw_u = 1'b0; saw_fail = 1'b0;
        step(1'b1, SI);
        for (int i = 0; i < CODE_LEN; i++) begin
            step(1'b0, seq[3*i +: 3]);
            saw_u |= U; saw_fail |= Fail;
        end
        step(1'b0, SI);
    endtask

    typedef struct {
        bit         start;
        logic [2:0] sym;
        logic [3:0] exp;   // {U, Fail, Locked, Busy}
    } vec_t;

    vec_t vt[19];

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit su, sf;
        int lc, hits;
        logic [11:0] hit_code, cv, rc;
        logic [2:0]  rs;

        vt[0]  = '{1'b1, SI, 4'b0001}; vt[1]  = '{1'b0, SR, 4'b0001};
        vt[2]  = '{1'b0, SB, 4'b0001}; vt[3]  = '{1'b0, SG, 4'b0001};
        vt[4]  = '{1'b0, SR, 4'b1000}; vt[5]  = '{1'b0, SI, 4'b0000};
        vt[6]  = '{1'b1, SI, 4'b0001}; vt[7]  = '{1'b0, SR, 4'b0001};
        vt[8]  = '{1'b0, SG, 4'b0100}; vt[9]  = '{1'b0, SI, 4'b0000};
        vt[10] = '{1'b1, SI, 4'b0001}; vt[11] = '{1'b0, SR, 4'b0001};
        vt[12] = '{1'b0, SI, 4'b0001}; vt[13] = '{1'b0, SI, 4'b0001};
        vt[14] = '{1'b0, SI, 4'b0001}; vt[15] = '{1'b0, SB, 4'b0001};
        vt[16] = '{1'b0, SG, 4'b0001}; vt[17] = '{1'b0, SR, 4'b1000};
        vt[18] = '{1'b0, SI, 4'b0000};

        Rst = 1'b1; Start = 1'b0; {Red, Green, Blue} = '0; CodeLoad = 1'b0; CodeIn = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_outputs", {U, Fail, Locked, Busy}, 4'b0000);
        Rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            step(vt[i].start, vt[i].sym);
            check($sformatf("vec%0d", i), {U, Fail, Locked, Busy}, vt[i].exp);
        end

        // Three consecutive failures -> lockout of LOCK_CYCLES, Start ignored meanwhile
        for (int f = 0; f < 3; f++) begin
            step(1'b1, SI);
            step(1'b0, SG);
        end
        check("third_fail_lock", {Fail, Locked}, 2'b11);
        lc = 1;
        for (int k = 0; k < 40 && Locked; k++) begin
            step(1'b1, SR);
            if (Locked) lc++;
        end
        check("lock_len", lc, LOCK_CYCLES);
        check("start_ignored_in_lock", Busy, 1'b0);
        do_entry(DEF, su, sf);
        check("unlock_after_lock", {su, sf}, 2'b10);

        // Success clears the consecutive-failure count
        do_entry(WRONG, su, sf);
        do_entry(WRONG, su, sf);
        do_entry(DEF, su, sf);
        check("success_between_fails", su, 1'b1);
        do_entry(WRONG, su, sf);
        do_entry(WRONG, su, sf);
        check("no_lock_after_clear", {sf, Locked}, 2'b10);

        // Runtime code load
        step(1'b0, SI, 1'b1, BBBB);
        do_entry(BBBB, su, sf);
        check("loaded_code_unlocks", {su, sf}, 2'b10);
        do_entry(DEF, su, sf);
        check("old_code_fails", {su, sf}, 2'b01);
        step(1'b1, SI);
        step(1'b0, SI, 1'b1, DEF);
        for (int i = 0; i < 4; i++) step(1'b0, SB);
        check("load_in_entry_ignored", U, 1'b1);
        step(1'b0, SI);
        step(1'b0, SI, 1'b1, 12'b011_100_100_100);
        do_entry(BBBB, su, sf);
        check("invalid_load_ignored", su, 1'b1);

        // Asynchronous reset mid-entry restores the default code
        step(1'b1, SI);
        step(1'b0, SB);
        #2 Rst = 1'b1;
        #1;
        check("async_reset", {U, Fail, Locked, Busy}, 4'b0000);
        model_reset();
        @(posedge Clk);
        #1 Rst = 1'b0;
        do_entry(DEF, su, sf);
        check("default_after_reset", su, 1'b1);
        do_entry(BBBB, su, sf);
        check("loaded_lost_after_reset", {su, sf}, 2'b01);

`ifdef CODE_TIMEOUT_EN
        step(1'b1, SI);
        step(1'b0, SR);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step(1'b0, SI);
        check("idle_below_timeout", {Fail, Busy}, 2'b01);
        step(1'b0, SI);
        check("timeout_fail", {Fail, Busy}, 2'b10);
        step(1'b1, SI);
        step(1'b0, SR);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step(1'b0, SI);
        step(1'b0, SB); step(1'b0, SG); step(1'b0, SR);
        check("idle_then_unlock", U, 1'b1);
        step(1'b0, SI);
`endif

        // Exhaustive sweep of all 4-symbol 3-bit patterns
        Rst = 1'b1; #1; model_reset(); @(posedge Clk); #1 Rst = 1'b0;
        hits = 0; hit_code = '0;
        for (int c = 0; c < 4096; c++) begin
            for (int k = 0; k < 40 && m_phase == 3; k++) step(1'b0, SI);
            cv = c[11:0];
            step(1'b1, SI);
            for (int i = 0; i < CODE_LEN; i++) begin
                step(1'b0, cv[3*i +: 3]);
                if (U) begin hits++; hit_code = cv; end
            end
            step(1'b0, SI);
        end
        check("sweep_hits", hits, 1);
        check("sweep_code", hit_code, DEF);

        // Random stimulus, biased toward the expected symbol so unlocks happen
        for (int n = 0; n < 3000; n++) begin
            if (m_phase == 1 && $urandom_range(0, 9) < 6) rs = m_code[typed.size()];
            else if ($urandom_range(0, 2) == 0) rs = SI;
            else rs = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < CODE_LEN; i++) rc[3*i +: 3] = 3'b001 << $urandom_range(0, 2);
            end else begin
                rc = 12'($urandom);
            end
            step($urandom_range(0, 9) == 0, rs, $urandom_range(0, 19) == 0, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
